// File: rtl/comp_pkg.sv
// Shared types for the key-search controller: FSM state encoding and key width.
package comp_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/comp_4bits.sv
// 4-bit equality comparator datapath shared by the search controller.
module comp_4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       EQ
);

  assign EQ = (A == B);

endmodule

// File: rtl/comp_search_ctrl.sv
// Sequential key search: scans a small table one entry per clock through a single
// shared comp_4bits instance and reports the lowest matching valid index.
module comp_search_ctrl
  import comp_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = 4,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            clr_all,
  input  logic            start,
  input  logic [W-1:0]    key,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic [IDXW-1:0] idx
);

  // Handshake: start is accepted on a rising edge where busy=0; done pulses for
  // one cycle when hit/idx are final; writes and clears only take effect while busy=0.

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   ptr;
  key_t              key_q;
  key_t              entries [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              eq;
  logic              match;
  logic              last;

  comp_4bits u_comp (
    .A  (entries[ptr]),
    .B  (key_q),
    .EQ (eq)
  );

  assign match = eq && valid[ptr];
  assign last  = (ptr == IDXW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (match || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SCAN:    busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Table updates are gated to IDLE so the scan always sees a frozen table;
  // clear precedes write so a same-cycle write survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (state == IDLE) begin
      if (clr_all) begin
        valid <= '0;
      end
      if (wr_en) begin
        valid[wr_addr]   <= 1'b1;
        entries[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      key_q <= '0;
      hit   <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= key;
            ptr   <= '0;
            hit   <= 1'b0;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            hit <= 1'b1;
            idx <= ptr;
          end else if (last) begin
            hit <= 1'b0;
            idx <= '0;
          end else begin
            ptr <= ptr + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_search_ctrl.sv
// Directed bench for comp_search_ctrl with a table-level reference model checked every cycle.
module tb_comp_search_ctrl;

  localparam int DEPTH = 16;
  localparam int IDXW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [IDXW-1:0] wr_addr = '0;
  logic [3:0]      wr_data = '0;
  logic            clr_all = 1'b0;
  logic            start = 1'b0;
  logic [3:0]      key = '0;
  logic            busy;
  logic            done;
  logic            hit;
  logic [IDXW-1:0] idx;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  comp_search_ctrl #(.DEPTH(DEPTH), .W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_all (clr_all),
    .start   (start),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .hit     (hit),
    .idx     (idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table contents plus the promised result and the cycle it appears.
  logic [3:0] m_tbl [DEPTH];
  bit         m_vld [DEPTH];
  bit         m_busy, m_done, m_hit, r_hit;
  int         m_idx, r_idx, cyc, done_at, lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_hit = 0; m_idx = 0; cyc = 0; done_at = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_tbl[i] = '0;
        m_vld[i] = 0;
      end
    end else begin
      cyc++;
      if (!m_busy) begin
        if (clr_all) for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        if (wr_en) begin
          m_tbl[wr_addr] = wr_data;
          m_vld[wr_addr] = 1;
        end
        if (start) begin
          r_hit = 0; r_idx = 0; lat = DEPTH + 1;
          for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_vld[i] && m_tbl[i] == key) begin
              r_hit = 1; r_idx = i; lat = i + 2;
            end
          end
          done_at = cyc + lat - 1;
          m_busy = 1; m_hit = 0; m_idx = 0;
        end
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (cyc == done_at) begin
        m_done = 1; m_hit = r_hit; m_idx = r_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("hit",  int'(hit),  int'(m_hit));
      chk("idx",  int'(idx),  m_idx);
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a pulse", n);
    end
  endtask

  // Called at posedge+2 in an idle cycle; returns at posedge+2 after the done cycle.
  task automatic run_search(input string name, input logic [3:0] k,
                            input int exp_hit, input int exp_idx, input int exp_lat);
    int n;
    start = 1'b1;
    key   = k;
    @(posedge clk); #2;
    start = 1'b0; wr_en = 1'b0; clr_all = 1'b0;
    wait_done(n);
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_hit"}, int'(hit), exp_hit);
    chk({name, "_idx"}, int'(idx), exp_idx);
    @(posedge clk); #2;
  endtask

  task automatic write_entry(input int a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = IDXW'(a);
    wr_data = d;
    @(posedge clk); #2;
    wr_en   = 1'b0;
    clr_all = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit",  int'(hit),  0);
    chk("rst_idx",  int'(idx),  0);
    @(posedge clk); #2;

    for (int i = 0; i < DEPTH; i++) write_entry(i, 4'(15 - i));
    run_search("desc9", 4'd9, 1, 6, 8);

    write_entry(3, 4'd5);
    write_entry(10, 4'd5);
    run_search("multi5", 4'd5, 1, 3, 5);

    clr_all = 1'b1;
    write_entry(2, 4'd7);
    run_search("miss0", 4'd0, 0, 0, 17);
    run_search("only7", 4'd7, 1, 2, 4);

    // Write and start presented mid-scan must be ignored.
    start = 1'b1; key = 4'd4;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 4'd4; start = 1'b1; key = 4'd7;
    @(posedge clk); #2;
    wr_en = 1'b0; start = 1'b0;
    wait_done(n);
    chk("busy_scan_lat", n, 15);
    chk("busy_scan_hit", int'(hit), 0);
    @(posedge clk); #2;
    run_search("nowrite4", 4'd4, 0, 0, 17);

    // Reset in cycle 3 of a scan.
    start = 1'b1; key = 4'd7;
    @(posedge clk); #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_hit",  int'(hit),  0);
    chk("abort_idx",  int'(idx),  0);
    @(posedge clk); #2 rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    @(posedge clk); #2;
    run_search("empty7", 4'd7, 0, 0, 17);

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd12;
    run_search("wr_start12", 4'd12, 1, 0, 2);
    run_search("again12", 4'd12, 1, 0, 2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
